// File: rtl/sar_adc_controller.sv
// Successive-approximation controller that drives an R2R ladder DAC and
// samples an external comparator to binary-search the input voltage.
module sar_adc_controller #(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 100
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             start,
    input  logic             continuous,
    input  logic             comp_in,
    output logic [WIDTH-1:0] R2R_out,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [IDX_W-1:0] MSB_IDX   = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_RLD   = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [WIDTH-1:0] MSB_TRIAL = WIDTH'(1) << (WIDTH - 1);

    generate
        if (SETTLE_CYCLES < 3) begin : g_settle_chk
            $error("sar_adc_controller: SETTLE_CYCLES must be at least 3");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DECIDE = 2'd2,
        DONE   = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] trial_q, trial_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, comp_s_q;

    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] trial_kept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            trial_q  <= '0;
            result_q <= '0;
            idx_q    <= MSB_IDX;
            cnt_q    <= '0;
            sync1_q  <= 1'b0;
            comp_s_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            trial_q  <= trial_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            sync1_q  <= comp_in;
            comp_s_q <= sync1_q;
        end
    end

    assign bit_mask = WIDTH'(1) << idx_q;

    always_comb begin
        state_d    = state_q;
        trial_d    = trial_q;
        result_d   = result_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        trial_kept = comp_s_q ? trial_q : (trial_q & ~bit_mask);

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    trial_d = MSB_TRIAL;
                    idx_d   = MSB_IDX;
                    cnt_d   = CNT_RLD;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = DECIDE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DECIDE: begin
                if (idx_q == '0) begin
                    trial_d  = trial_kept;
                    result_d = trial_kept;
                    state_d  = DONE;
                end else begin
                    // Commit the decided bit and tentatively set the next one down.
                    trial_d = trial_kept | (bit_mask >> 1);
                    idx_d   = idx_q - IDX_W'(1);
                    cnt_d   = CNT_RLD;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                if (continuous) begin
                    trial_d = MSB_TRIAL;
                    idx_d   = MSB_IDX;
                    cnt_d   = CNT_RLD;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything: park the ladder at zero, keep the last result.
        if (!enable) begin
            state_d  = IDLE;
            trial_d  = '0;
            result_d = result_q;
        end
    end

    assign R2R_out = trial_q;
    assign result  = result_q;
    assign busy    = (state_q == SETTLE) || (state_q == DECIDE);
    assign done    = (state_q == DONE);

endmodule

// File: doc/sar_adc_controller.md
# sar_adc_controller

Successive-approximation controller for the R2R ladder DAC and external comparator. It sequences a binary search over the ladder code, samples the comparator after a programmable settling delay, and returns the converted code with a one-cycle done strobe. It sits between the system logic and the R2R ladder pins, and replaces the free-running triangle ramp whenever a conversion is requested.

## Interface
- WIDTH, 8: ladder and result bit width.
- SETTLE_CYCLES, 100: clocks allowed for ladder and comparator settling per bit trial. Must be ≥ 3; elaboration error otherwise.
- clk  input  1  system clock (100 MHz).
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  active-high; low aborts and holds the block idle.
- start  input  1  conversion request, sampled only in IDLE.
- continuous  input  1  when high, the next conversion starts immediately after DONE.
- comp_in  input  1  asynchronous comparator output: 1 = Vin ≥ Vdac.
- R2R_out  output  WIDTH  ladder drive code.
- result  output  WIDTH  last completed conversion.
- busy  output  1  high in SETTLE and DECIDE.
- done  output  1  one-cycle pulse; result is valid that cycle.

## Operation
- Reset values: state = IDLE; R2R_out = 0, result = 0, busy = 0, done = 0; bit index = WIDTH-1; settle counter = 0; synchronizer flops = 0.
- comp_in passes through a 2-flop synchronizer (comp_s). The settle window hides this latency.
- States:
  - IDLE: R2R_out holds its value. On enable & start: trial = 1 << (WIDTH-1), R2R_out = trial, bit index = WIDTH-1, counter = SETTLE_CYCLES-1, go to SETTLE.
  - SETTLE: counter decrements each cycle. When counter == 0, go to DECIDE. The state lasts exactly SETTLE_CYCLES cycles.
  - DECIDE (1 cycle): if comp_s == 0, clear trial[bit index]. If bit index == 0, result = final trial and go to DONE. Otherwise set trial[bit index-1], decrement the bit index, reload the counter, and go to SETTLE. R2R_out tracks trial (registered).
  - DONE (1 cycle): done = 1. If continuous & enable, restart exactly as from IDLE on start. Otherwise go to IDLE.
- enable low in any state: next state IDLE, R2R_out = 0, trial cleared, no done. result keeps its previous value.
- start while not IDLE is ignored; no queuing. start and enable low in the same cycle: ignored.
- R2R_out holds the final code in DONE and IDLE until the next start or abort.
- All arithmetic is unsigned WIDTH-bit. The bit index is $clog2(WIDTH) bits and never wraps below 0.

## Timing
- Let S = SETTLE_CYCLES and W = WIDTH. start is sampled at edge 0.
- busy rises at cycle 1. The MSB trial is on R2R_out at cycle 1.
- The DECIDE for bit i (counting from the MSB, 1-based) occurs at cycle i·(S+1).
- done and the new result appear at cycle W·(S+1)+1. busy is low that cycle.
- Continuous mode: the conversion period is W·(S+1)+1 cycles, with no IDLE gap.
- comp_in must be stable from cycle (DECIDE − S + 2) through the DECIDE cycle.
- reset_n assertion takes effect asynchronously. Deassertion is synchronized externally; the first start is accepted on the first edge after release.

## Test plan
Bench settings: W = 8, S = 4. Ideal comparator model: comp_in = (vin ≥ R2R_out).
- vin = 0xA5, single start pulse:
  - R2R_out sequence: 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
  - done at cycle 41 with result = 0xA5.
  - busy is high for cycles 1–40.
- vin = 0x00, then a second conversion with vin = 0xFF:
  - results 0x00 and 0xFF.
  - exactly one done pulse per conversion.
- start re-pulsed at cycles 5 and 20 during a conversion: ignored. The single done still occurs at cycle 41 and result is unchanged by the extra pulses.
- continuous = 1, vin = 0x3C:
  - done pulses at cycles 41, 82, 123, each with result = 0x3C.
  - after continuous drops, the block returns to IDLE following the next done.
- enable dropped at cycle 17:
  - IDLE at cycle 18 with R2R_out = 0 and busy = 0.
  - no done; result keeps the prior value.
  - a new start converts correctly.
- reset_n asserted at cycle 25 mid-conversion: all outputs return to their reset values immediately, without waiting for a clock edge. A subsequent conversion with vin = 0x5A gives result = 0x5A.
